// File: rtl/state_xfer_tx_pkg.sv
// Shared definitions for the state-transfer CDC channel (transmitter and receiver).
package state_xfer_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SETUP    = 2'd1,
        WAIT_ACK = 2'd2
    } state_t;

    localparam int unsigned DROP_CNT_W      = 8;
    localparam int unsigned DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/state_xfer_tx_if.sv
// Update input and toggle-handshake bus of the state-transfer transmitter.
interface state_xfer_tx_if #(
    parameter int unsigned bits = 8
);
    logic            upd_valid;
    logic [bits-1:0] upd_data;
    logic            upd_ready;
    logic [bits-1:0] xfer_data;
    logic            xfer_req;
    logic            xfer_ack;

    modport slave (
        input  upd_valid, upd_data, xfer_ack,
        output upd_ready, xfer_data, xfer_req
    );

    modport master (
        output upd_valid, upd_data, xfer_ack,
        input  upd_ready, xfer_data, xfer_req
    );
endinterface

// File: rtl/state_xfer_tx_sync_bit_rst.sv
// N-stage single-bit synchronizer with asynchronous active-low reset.
module sync_bit_rst #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ff <= '0;
        else        ff <= {ff[STAGES-2:0], d};
    end

    assign q = ff[STAGES-1];
endmodule

// File: rtl/state_xfer_tx.sv
// Source end of the toggle-handshake channel: holds one value on xfer_data,
// toggles xfer_req, and waits for the synchronized ack toggle to match.
module state_xfer_tx
    import state_xfer_pkg::*;
#(
    parameter int unsigned bits        = 8,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int unsigned COALESCE    = 1,
    parameter int unsigned TIMEOUT     = 0
) (
    input  logic                  clk_50,
    input  logic                  reset_n,
    state_xfer_tx_if.slave        xfer,
    output logic                  busy,
    output logic [DROP_CNT_W-1:0] drop_cnt,
    output logic                  timeout_err,
    input  logic                  clr_err
);
    localparam int unsigned   TW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT);
    localparam logic [TW-1:0] TMO_HIT = TW'(TIMEOUT - 1);

    state_t          state;
    logic            ack_s;
    logic            pend_valid;
    logic [bits-1:0] pend_data;
    logic [TW-1:0]   timer;

    logic idle, upd_ready_i, accept, take_upd, take_pend, wr_pend, drop_evt, tmo_evt;

    sync_bit_rst #(.STAGES(SYNC_STAGES)) u_ack_sync (
        .clk   (clk_50),
        .rst_n (reset_n),
        .d     (xfer.xfer_ack),
        .q     (ack_s)
    );

    // Pending-vs-new priority in IDLE: with COALESCE the fresh update wins and the
    // stale pending value is dropped; a pending value is dropped on overwrite too.
    always_comb begin
        idle        = (state == IDLE);
        upd_ready_i = (COALESCE != 0) ? 1'b1 : ~pend_valid;
        accept      = xfer.upd_valid && upd_ready_i;
        take_upd    = idle && accept;
        take_pend   = idle && pend_valid && !take_upd;
        wr_pend     = !idle && accept;
        drop_evt    = (COALESCE != 0) && pend_valid && accept;
        tmo_evt     = (TIMEOUT != 0) && (state == WAIT_ACK) && (timer == TMO_HIT);
    end

    assign xfer.upd_ready = upd_ready_i;
    assign busy           = !idle;

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            xfer.xfer_data <= '0;
            xfer.xfer_req  <= 1'b0;
            timer          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (take_upd) begin
                        xfer.xfer_data <= xfer.upd_data;
                        state          <= SETUP;
                    end else if (take_pend) begin
                        xfer.xfer_data <= pend_data;
                        state          <= SETUP;
                    end
                end
                SETUP: begin
                    xfer.xfer_req <= ~xfer.xfer_req;
                    timer         <= '0;
                    state         <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (ack_s == xfer.xfer_req) state <= IDLE;
                    if (timer != TMO_MAX)       timer <= timer + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            pend_valid <= 1'b0;
            pend_data  <= '0;
        end else if (wr_pend) begin
            pend_valid <= 1'b1;
            pend_data  <= xfer.upd_data;
        end else if (idle) begin
            pend_valid <= 1'b0;
        end
    end

    // Set/increment events take precedence over a coincident clr_err.
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (drop_evt) begin
                if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
            end else if (clr_err) begin
                drop_cnt <= '0;
            end
            if (tmo_evt)      timeout_err <= 1'b1;
            else if (clr_err) timeout_err <= 1'b0;
        end
    end
endmodule

// File: tb/tb_state_xfer_tx.sv
// Directed bench for state_xfer_tx: coalescing/timeout, back-pressure and stress instances.
module tb_state_xfer_tx;
    logic clk_50  = 1'b0;
    logic reset_n = 1'b0;
    logic clr_err = 1'b0;

    always #5 clk_50 = ~clk_50;

    state_xfer_tx_if #(.bits(8))  ifc ();
    state_xfer_tx_if #(.bits(8))  ifb ();
    state_xfer_tx_if #(.bits(16)) ifs ();

    logic       busy_c, busy_b, busy_s;
    logic [7:0] drop_c, drop_b, drop_s;
    logic       terr_c, terr_b, terr_s;

    int total = 0;
    int bad   = 0;

    state_xfer_tx #(.bits(8), .SYNC_STAGES(2), .COALESCE(1), .TIMEOUT(16)) dut_c (
        .clk_50(clk_50), .reset_n(reset_n), .xfer(ifc), .busy(busy_c),
        .drop_cnt(drop_c), .timeout_err(terr_c), .clr_err(clr_err));

    state_xfer_tx #(.bits(8), .SYNC_STAGES(2), .COALESCE(0), .TIMEOUT(0)) dut_b (
        .clk_50(clk_50), .reset_n(reset_n), .xfer(ifb), .busy(busy_b),
        .drop_cnt(drop_b), .timeout_err(terr_b), .clr_err(clr_err));

    state_xfer_tx #(.bits(16), .SYNC_STAGES(2), .COALESCE(1), .TIMEOUT(0)) dut_s (
        .clk_50(clk_50), .reset_n(reset_n), .xfer(ifs), .busy(busy_s),
        .drop_cnt(drop_s), .timeout_err(terr_s), .clr_err(clr_err));

    task automatic tick;
        @(posedge clk_50);
        #1;
    endtask

    function automatic logic busy_of(input int sel);
        return (sel == 0) ? busy_c : (sel == 1) ? busy_b : busy_s;
    endfunction

    task automatic wait_idle(input int sel, input string name);
        int n;
        n = 0;
        while (busy_of(sel) && n < 50) begin
            tick;
            n++;
        end
        total++;
        if (busy_of(sel) !== 1'b0) begin
            $display("FAIL %s: busy=%b after %0d cycles, want 0", name, busy_of(sel), n);
            bad++;
        end
    endtask

    task automatic test_reset;
        ifc.upd_valid = 0; ifc.upd_data = '0; ifc.xfer_ack = 0;
        ifb.upd_valid = 0; ifb.upd_data = '0; ifb.xfer_ack = 0;
        ifs.upd_valid = 0; ifs.upd_data = '0; ifs.xfer_ack = 0;
        reset_n = 0;
        #23;
        total += 8;
        if (ifc.xfer_data !== 8'h00) begin $display("FAIL rst_data: got %h want 00", ifc.xfer_data); bad++; end
        if (ifc.xfer_req !== 1'b0)   begin $display("FAIL rst_req: got %b want 0", ifc.xfer_req); bad++; end
        if (busy_c !== 1'b0)         begin $display("FAIL rst_busy: got %b want 0", busy_c); bad++; end
        if (drop_c !== 8'd0)         begin $display("FAIL rst_drop: got %0d want 0", drop_c); bad++; end
        if (terr_c !== 1'b0)         begin $display("FAIL rst_terr: got %b want 0", terr_c); bad++; end
        if (ifc.upd_ready !== 1'b1)  begin $display("FAIL rst_ready_c: got %b want 1", ifc.upd_ready); bad++; end
        if (ifb.upd_ready !== 1'b1)  begin $display("FAIL rst_ready_b: got %b want 1", ifb.upd_ready); bad++; end
        if (busy_b !== 1'b0)         begin $display("FAIL rst_busy_b: got %b want 0", busy_b); bad++; end
        reset_n = 1;
        tick;
        tick;
    endtask

    task automatic test_single;
        ifc.upd_valid = 1; ifc.upd_data = 8'hA5;
        tick;
        ifc.upd_valid = 0;
        total += 3;
        if (ifc.xfer_data !== 8'hA5) begin $display("FAIL single_data: got %h want a5", ifc.xfer_data); bad++; end
        if (busy_c !== 1'b1)         begin $display("FAIL single_busy1: got %b want 1", busy_c); bad++; end
        if (ifc.xfer_req !== 1'b0)   begin $display("FAIL single_req_early: got %b want 0", ifc.xfer_req); bad++; end
        tick;
        total += 2;
        if (ifc.xfer_req !== 1'b1) begin $display("FAIL single_req: got %b want 1", ifc.xfer_req); bad++; end
        if (busy_c !== 1'b1)       begin $display("FAIL single_busy2: got %b want 1", busy_c); bad++; end
        ifc.xfer_ack = 1;
        tick;
        tick;
        total++;
        if (busy_c !== 1'b1) begin $display("FAIL single_busy_hold: got %b want 1", busy_c); bad++; end
        tick;
        total += 2;
        if (busy_c !== 1'b0) begin $display("FAIL single_busy_drop: got %b want 0", busy_c); bad++; end
        if (drop_c !== 8'd0) begin $display("FAIL single_drop: got %0d want 0", drop_c); bad++; end
    endtask

    task automatic test_coalesce;
        int n;
        int toggles;
        logic prev;
        ifc.upd_valid = 1; ifc.upd_data = 8'h77;
        tick;
        ifc.upd_data = 8'h11; tick;
        ifc.upd_data = 8'h22; tick;
        ifc.upd_data = 8'h33; tick;
        ifc.upd_valid = 0;
        total += 3;
        if (drop_c !== 8'd2)         begin $display("FAIL coal_drop_mid: got %0d want 2", drop_c); bad++; end
        if (ifc.xfer_data !== 8'h77) begin $display("FAIL coal_hold: got %h want 77", ifc.xfer_data); bad++; end
        if (ifc.xfer_req !== 1'b0)   begin $display("FAIL coal_req0: got %b want 0", ifc.xfer_req); bad++; end
        ifc.xfer_ack = 1'b0;
        n = 0;
        while (ifc.xfer_req === 1'b0 && n < 20) begin
            tick;
            n++;
        end
        total += 3;
        if (ifc.xfer_req !== 1'b1)   begin $display("FAIL coal_next_req: got %b want 1", ifc.xfer_req); bad++; end
        if (ifc.xfer_data !== 8'h33) begin $display("FAIL coal_next_data: got %h want 33", ifc.xfer_data); bad++; end
        if (drop_c !== 8'd2)         begin $display("FAIL coal_drop: got %0d want 2", drop_c); bad++; end
        ifc.xfer_ack = 1'b1;
        wait_idle(0, "coal_idle");
        toggles = 0;
        prev = ifc.xfer_req;
        for (int i = 0; i < 10; i++) begin
            tick;
            if (ifc.xfer_req !== prev) toggles++;
            prev = ifc.xfer_req;
        end
        total += 2;
        if (toggles != 0)    begin $display("FAIL coal_extra_req: got %0d toggles want 0", toggles); bad++; end
        if (busy_c !== 1'b0) begin $display("FAIL coal_final_busy: got %b want 0", busy_c); bad++; end
    endtask

    task automatic test_backpressure;
        logic [7:0] log_v[2];
        int   nlog;
        int   n;
        logic acc;
        logic last_req;
        ifb.upd_valid = 1; ifb.upd_data = 8'h44;
        tick;
        ifb.upd_data = 8'h11;
        tick;
        total++;
        if (ifb.upd_ready !== 1'b0) begin $display("FAIL bp_ready: got %b want 0", ifb.upd_ready); bad++; end
        ifb.upd_data = 8'h22;
        last_req = ifb.xfer_req;
        ifb.xfer_ack = ifb.xfer_req;
        nlog = 0;
        n = 0;
        while (n < 80 && !(nlog >= 2 && !busy_b && !ifb.upd_valid)) begin
            acc = ifb.upd_valid && ifb.upd_ready;
            tick;
            n++;
            if (acc) ifb.upd_valid = 0;
            if (ifb.xfer_req !== last_req) begin
                last_req = ifb.xfer_req;
                if (nlog < 2) log_v[nlog] = ifb.xfer_data;
                nlog++;
                ifb.xfer_ack = ifb.xfer_req;
            end
        end
        total += 4;
        if (nlog != 2) begin $display("FAIL bp_count: got %0d want 2", nlog); bad++; end
        if (nlog >= 1 && log_v[0] !== 8'h11) begin $display("FAIL bp_first: got %h want 11", log_v[0]); bad++; end
        if (nlog >= 2 && log_v[1] !== 8'h22) begin $display("FAIL bp_second: got %h want 22", log_v[1]); bad++; end
        if (drop_b !== 8'd0) begin $display("FAIL bp_drop: got %0d want 0", drop_b); bad++; end
        wait_idle(1, "bp_idle");
    endtask

    task automatic test_timeout;
        clr_err = 1;
        tick;
        clr_err = 0;
        total++;
        if (drop_c !== 8'd0) begin $display("FAIL clr_drop: got %0d want 0", drop_c); bad++; end
        ifc.upd_valid = 1; ifc.upd_data = 8'h66;
        tick;
        ifc.upd_valid = 0;
        tick;
        repeat (15) tick;
        total += 2;
        if (terr_c !== 1'b0) begin $display("FAIL tmo_early: got %b want 0", terr_c); bad++; end
        if (busy_c !== 1'b1) begin $display("FAIL tmo_busy_early: got %b want 1", busy_c); bad++; end
        tick;
        total++;
        if (terr_c !== 1'b1) begin $display("FAIL tmo_set: got %b want 1", terr_c); bad++; end
        repeat (5) tick;
        total += 2;
        if (terr_c !== 1'b1) begin $display("FAIL tmo_sticky: got %b want 1", terr_c); bad++; end
        if (busy_c !== 1'b1) begin $display("FAIL tmo_busy: got %b want 1", busy_c); bad++; end
        clr_err = 1;
        tick;
        clr_err = 0;
        tick;
        total += 2;
        if (terr_c !== 1'b0)         begin $display("FAIL tmo_clr: got %b want 0", terr_c); bad++; end
        if (ifc.xfer_data !== 8'h66) begin $display("FAIL tmo_data: got %h want 66", ifc.xfer_data); bad++; end
        ifc.xfer_ack = ifc.xfer_req;
        wait_idle(0, "tmo_late_ack");
        total++;
        if (terr_c !== 1'b0) begin $display("FAIL tmo_after: got %b want 0", terr_c); bad++; end
    endtask

    task automatic test_reset_mid;
        ifc.upd_valid = 1; ifc.upd_data = 8'h99;
        tick;
        ifc.upd_valid = 0;
        tick;
        #2 reset_n = 0;
        #1;
        total += 5;
        if (busy_c !== 1'b0)         begin $display("FAIL mid_busy: got %b want 0", busy_c); bad++; end
        if (ifc.xfer_req !== 1'b0)   begin $display("FAIL mid_req: got %b want 0", ifc.xfer_req); bad++; end
        if (ifc.xfer_data !== 8'h00) begin $display("FAIL mid_data: got %h want 00", ifc.xfer_data); bad++; end
        if (terr_c !== 1'b0)         begin $display("FAIL mid_terr: got %b want 0", terr_c); bad++; end
        if (ifc.upd_ready !== 1'b1)  begin $display("FAIL mid_ready: got %b want 1", ifc.upd_ready); bad++; end
        ifc.xfer_ack = 0; ifb.xfer_ack = 0; ifs.xfer_ack = 0;
        #3 reset_n = 1;
        tick;
        ifc.upd_valid = 1; ifc.upd_data = 8'h5A;
        tick;
        ifc.upd_valid = 0;
        total++;
        if (ifc.xfer_data !== 8'h5A) begin $display("FAIL mid_fresh_data: got %h want 5a", ifc.xfer_data); bad++; end
        tick;
        total++;
        if (ifc.xfer_req !== 1'b1) begin $display("FAIL mid_fresh_req: got %b want 1", ifc.xfer_req); bad++; end
        ifc.xfer_ack = 1;
        wait_idle(0, "mid_fresh_idle");
    endtask

    task automatic test_back_to_back;
        logic prod_done;
        int   rx_cnt;
        int   exp_drop;
        logic [15:0] last_rx;
        prod_done = 0;
        rx_cnt    = 0;
        last_rx   = '0;
        fork
            begin
                for (int i = 1; i <= 1000; i++) begin
                    ifs.upd_valid = 1;
                    ifs.upd_data  = 16'(i);
                    tick;
                    ifs.upd_valid = 0;
                    repeat ($urandom_range(0, 3)) tick;
                end
                prod_done = 1;
            end
            begin
                logic        last_req;
                logic        outstanding;
                logic [15:0] held;
                int          countdown;
                int          cyc;
                int          quiet;
                last_req    = ifs.xfer_req;
                outstanding = 0;
                held        = '0;
                countdown   = 0;
                cyc         = 0;
                quiet       = 0;
                while (cyc < 20000 && quiet < 4) begin
                    tick;
                    cyc++;
                    if (ifs.xfer_req !== last_req) begin
                        last_req = ifs.xfer_req;
                        rx_cnt++;
                        total++;
                        if (ifs.xfer_data <= last_rx) begin
                            $display("FAIL b2b_monotonic: got %0d after %0d", ifs.xfer_data, last_rx);
                            bad++;
                        end
                        last_rx     = ifs.xfer_data;
                        held        = ifs.xfer_data;
                        countdown   = $urandom_range(2, 20);
                        outstanding = 1;
                    end else if (outstanding) begin
                        total++;
                        if (ifs.xfer_data !== held) begin
                            $display("FAIL b2b_stable: got %0d want %0d", ifs.xfer_data, held);
                            bad++;
                        end
                        countdown--;
                        if (countdown <= 0) begin
                            ifs.xfer_ack = ifs.xfer_req;
                            outstanding  = 0;
                        end
                    end
                    if (prod_done && !busy_s && !outstanding && ifs.xfer_req === ifs.xfer_ack) quiet++;
                    else quiet = 0;
                end
            end
        join
        exp_drop = (1000 - rx_cnt > 255) ? 255 : 1000 - rx_cnt;
        total += 3;
        if (last_rx !== 16'd1000) begin $display("FAIL b2b_last: got %0d want 1000", last_rx); bad++; end
        if (drop_s !== 8'(exp_drop)) begin $display("FAIL b2b_drop: got %0d want %0d", drop_s, exp_drop); bad++; end
        if (busy_s !== 1'b0) begin $display("FAIL b2b_busy: got %b want 0", busy_s); bad++; end
    endtask

    initial begin
        test_reset;
        test_single;
        test_coalesce;
        test_backpressure;
        test_timeout;
        test_reset_mid;
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end
endmodule

// File: doc/state_xfer_tx.md
Name: state_xfer_tx

Overview:
- Source end of a toggle-handshake CDC channel in the CLOCK_50 domain.
- Accepts multi-bit state updates from game logic and holds them stable on a data bus.
- Signals each new value to the VGA-domain receiver by toggling a request line, then waits for the receiver's returned acknowledge toggle before launching the next value.
- Holds one pending update during a transfer, optionally coalescing so only the newest value is sent.

Parameters:
- bits, 8, width of the state word.
- SYNC_STAGES, 2, flops in the xfer_ack synchronizer (min 2).
- COALESCE, 1, 1: newest update overwrites pending; 0: back-pressure via upd_ready.
- TIMEOUT, 0, max WAIT_ACK cycles before timeout_err sets; 0 disables.

Ports:
- clk_50  input  1  CLOCK_50 domain clock.
- reset_n  input  1  asynchronous active-low reset.
- upd_valid  input  1  update offered this cycle.
- upd_data  input  bits  update value.
- upd_ready  output  1  update accepted when upd_valid && upd_ready.
- xfer_data  output  bits  held data bus to receiver.
- xfer_req  output  1  request toggle to receiver.
- xfer_ack  input  1  ack toggle from VGA domain; asynchronous.
- busy  output  1  high in SETUP or WAIT_ACK.
- drop_cnt  output  8  count of overwritten pending updates, saturating at 255.
- timeout_err  output  1  sticky timeout flag.
- clr_err  input  1  synchronous clear of timeout_err and drop_cnt.

Behaviour:
- Interface: one clock, clk_50. Reset is reset_n, asynchronous and active-low.
- Reset values:
  - state = IDLE.
  - xfer_data = 0, xfer_req = 0.
  - ack synchronizer flops = 0.
  - pending empty.
  - drop_cnt = 0, timeout_err = 0, busy = 0.
  - upd_ready = 1.
- ack_s is the last stage of the SYNC_STAGES synchronizer on xfer_ack. A transfer is complete when ack_s == xfer_req.
- IDLE:
  - If pending valid, or upd_valid is high: load xfer_data at the edge and go to SETUP.
  - Source priority: if COALESCE=1 and both pending and upd_valid, upd_data wins, pending clears and drop_cnt increments. Otherwise pending wins.
- SETUP: for one cycle, xfer_data is stable. At the edge, xfer_req <= ~xfer_req, go to WAIT_ACK, timer <= 0.
- WAIT_ACK:
  - Stay until ack_s == xfer_req, then go to IDLE.
  - Timer increments each cycle. When TIMEOUT != 0 and timer reaches TIMEOUT, timeout_err sets and the block keeps waiting. There is no retransmit.
- Latency: accept at edge N gives xfer_data valid after edge N+1, xfer_req toggled after edge N+2. busy is high from edge N+1 until WAIT_ACK exits.
- xfer_data never changes outside the IDLE->SETUP transition. The receiver may sample it any time after it sees the toggle.
- Pending slot (written only when not IDLE):
  - COALESCE=1: upd_ready is always 1. A write to an occupied slot overwrites it and increments drop_cnt (saturating).
  - COALESCE=0: upd_ready = ~pending_valid. No drops.
- Accept in IDLE: upd_valid in IDLE with pending empty bypasses the slot.
- clr_err clears timeout_err and drop_cnt. If clr_err coincides with a set or increment event in the same cycle, the set/increment wins.
- Reset mid-transfer: everything returns to reset values. The receiver must be reset in the same reset event, or its request sync will see a stale toggle. This is a system-level requirement.
- Width: timer is $clog2(TIMEOUT+1) bits and saturates.

Decomposition:
- Shared package state_xfer_pkg holds:
  - state enum {IDLE, SETUP, WAIT_ACK}.
  - DROP_CNT_W = 8.
  - default SYNC_STAGES constant, shared with the receiver.
- One natural sub-module: sync_bit_rst, an N-stage single-bit synchronizer with asynchronous active-low reset, used for xfer_ack.

Test Plan:
- Single transfer:
  - Stimulus: reset, then upd_valid=1, upd_data=8'hA5 for 1 cycle.
  - Response: xfer_data=A5 after edge 1, xfer_req 0->1 after edge 2, busy=1. Drive xfer_ack=1, and busy drops 3 cycles later.
- Coalescing (COALESCE=1):
  - Stimulus: during WAIT_ACK, send 0x11, 0x22, 0x33.
  - Response: after ack, next xfer_data=0x33, drop_cnt=2, exactly one more req toggle.
- Back-pressure (COALESCE=0):
  - Stimulus: during WAIT_ACK, send 0x11 then hold 0x22.
  - Response: upd_ready=0 after 0x11. Sequence sent is 0x11 then 0x22, drop_cnt=0.
- Timeout (TIMEOUT=16):
  - Stimulus: never toggle xfer_ack.
  - Response: timeout_err=1 after 16 cycles in WAIT_ACK, stays busy. clr_err clears the flag. A late ack completes the transfer normally.
- Reset mid-transfer:
  - Stimulus: assert reset_n=0 asynchronously (off-edge) during WAIT_ACK.
  - Response: outputs go to reset values immediately, without waiting for a clock edge. After release, a fresh 0x5A update transfers correctly.
- Back-to-back stress:
  - Stimulus: 1000 random updates with a random-latency ack model (2-20 cycles).
  - Response: receiver observes a monotonic subsequence ending in the last value, and xfer_data is never seen changing while a request is outstanding.
